// File: rtl/i2s_sample_fifo_if.sv
// Sample and status bundle between the audio register file (master) and the
// sample FIFO (slave) feeding the I2S/DAC output stage.
interface i2s_sample_fifo_if #(
  parameter int unsigned FIFO_LEN_BITS = 4,
  parameter int unsigned DATA_WIDTH    = 48
);
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_valid;
  logic                   sample_req;
  logic [DATA_WIDTH-1:0]  sample_out;
  logic                   sample_out_valid;
  logic [FIFO_LEN_BITS:0] fifo_threshold;
  logic [FIFO_LEN_BITS:0] fifo_level;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_low;
  logic                   overflow;
  logic                   underrun;

  modport master (
    output wr_data, wr_valid, sample_req, fifo_threshold,
    input  sample_out, sample_out_valid, fifo_level, fifo_full,
           fifo_empty, fifo_low, overflow, underrun
  );

  modport slave (
    input  wr_data, wr_valid, sample_req, fifo_threshold,
    output sample_out, sample_out_valid, fifo_level, fifo_full,
           fifo_empty, fifo_low, overflow, underrun
  );
endinterface

// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO: register-file writes in, one word per output-stage
// request out, with level/low-water status and sticky overflow/underrun.
module i2s_sample_fifo #(
  parameter int unsigned FIFO_LEN_BITS = 4,
  parameter int unsigned DATA_WIDTH    = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               soft_rst,
  i2s_sample_fifo_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << FIFO_LEN_BITS;
  localparam logic [FIFO_LEN_BITS:0] LEVEL_FULL = {1'b1, {FIFO_LEN_BITS{1'b0}}};

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [FIFO_LEN_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LEN_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_LEN_BITS:0]   level_q, level_d;
  logic [DATA_WIDTH-1:0]    sample_out_q, sample_out_d;
  logic                     valid_q, valid_d;
  logic                     overflow_q, overflow_d;
  logic                     underrun_q, underrun_d;

  logic full, empty, do_pop, do_write;

  assign full  = (level_q == LEVEL_FULL);
  assign empty = (level_q == '0);

  // A request while full always pops, freeing the slot the same-cycle write uses.
  assign do_pop   = bus.sample_req && !empty && !soft_rst;
  assign do_write = bus.wr_valid && (!full || bus.sample_req) && !soft_rst;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    sample_out_d = sample_out_q;
    valid_d      = 1'b0;
    overflow_d   = overflow_q;
    underrun_d   = underrun_q;

    if (soft_rst) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      sample_out_d = '0;
      overflow_d   = 1'b0;
      underrun_d   = 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else if (bus.wr_valid) begin
        overflow_d = 1'b1;
      end

      if (bus.sample_req) begin
        valid_d = 1'b1;
        if (do_pop) begin
          sample_out_d = mem_q[rd_ptr_q];
          rd_ptr_d     = rd_ptr_q + 1'b1;
        end else begin
          sample_out_d = '0;
          underrun_d   = 1'b1;
        end
      end

      unique case ({do_write, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      sample_out_q <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      sample_out_q <= sample_out_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus.sample_out       = sample_out_q;
  assign bus.sample_out_valid = valid_q;
  assign bus.fifo_level       = level_q;
  assign bus.fifo_full        = full;
  assign bus.fifo_empty       = empty;
  assign bus.fifo_low         = (level_q < bus.fifo_threshold);
  assign bus.overflow         = overflow_q;
  assign bus.underrun         = underrun_q;

endmodule
